cache_refill: RTL and testbench
===============================

// Module: cache_refill
// PURPOSE
//  Line-fill engine that writes the cache data array (4 banks x 8-bit RAMs, 10-bit word addr).
//  On a miss it issues one wrapping 4-beat read burst to memory, critical word first.
//  Each returned beat is written into the data array; the critical word is forwarded to the core.
//  Done or error is reported to the cache controller, which then updates tag/valid.
// PARAMETERS
//  ADDR_WIDTH   32  byte address width of miss/memory address
//  DATA_WIDTH   32  beat/word width (= `DATA_WIDTH)
//  BANK_NUM      4  byte banks per word (= `RAM_NUM); also beats per line
//  RAM_AW       10  data-array word address width (= `CACHE_RAM_AW) = INDEX(8) + WORD_OFS(2)
// PORTS
//  clk              in   1        single clock
//  rst_n            in   1        asynchronous active-low reset
//  refill_req_i     in   1        start refill; sampled only when busy_o==0
//  miss_addr_i      in   32       miss byte addr: [31:12] tag, [11:4] index, [3:2] word, [1:0] byte
//  busy_o           out  1        1 from accepted request until the cycle after done/err pulse
//  mem_req_valid_o  out  1        burst request valid
//  mem_req_ready_i  in   1        memory accepts request
//  mem_req_addr_o   out  32       {miss_addr[31:2],2'b00}, wrap burst length 4
//  mem_rsp_valid_i  in   1        response beat valid
//  mem_rsp_ready_o  out  1        engine accepts beat
//  mem_rsp_data_i   in   32       beat data
//  mem_rsp_err_i    in   1        beat carries bus error
//  mem_rsp_last_i   in   1        final beat of burst
//  wr_en_o          out  4        data-array byte-bank write enables
//  wr_addr_o        out  10       data-array word address {index, word}
//  wr_data_o        out  32       data-array write data
//  crit_valid_o     out  1        1-cycle pulse: critical word available
//  crit_data_o      out  32       critical word
//  refill_done_o    out  1        1-cycle pulse: line written without error
//  refill_err_o     out  1        1-cycle pulse: burst completed with >=1 error beat
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (wr_en_o=4'b0, addresses/data 0); beat counter, err flag 0.
//  FSM IDLE->REQ->RECV->FIN->IDLE.
//  - IDLE: busy_o=0, mem_rsp_ready_o=0. refill_req_i=1 -> latch index, crit word ofs, addr; go REQ.
//  - REQ: mem_req_valid_o=1, addr stable until mem_req_ready_i; on handshake -> RECV, beat_ofs=crit ofs.
//  - RECV: mem_rsp_ready_o=1. Each accepted beat (valid&ready) at cycle N:
//      cycle N+1: wr_en_o=4'b1111, wr_addr_o={index,beat_ofs}, wr_data_o=beat (suppressed, wr_en=0,
//      if err flag set or this beat errs); beat_ofs=beat_ofs+1 mod 4 (3 wraps to 0).
//      First beat also drives crit_valid_o=1, crit_data_o=beat at N+1 (not if that beat errs).
//      Beat with mem_rsp_last_i -> FIN. Gaps (valid=0) allowed indefinitely.
//  - FIN: last write is already on the array port this cycle; pulse refill_done_o if err flag==0,
//      else refill_err_o; clear err flag; -> IDLE. done/err never both high.
//  Error: any err beat sets sticky err flag; remaining beats still drained (ready held) till last.
//  Latency, no stalls: req handshake at T -> writes T+2..T+5 -> done at T+5 (FIN coincides w/ last wr).
//  refill_req_i while busy_o=1 is ignored (no queuing). rsp beats outside RECV never accepted.
//  Exactly 4 beats expected; last before 4th or 5th beat without last: set err flag, treat as last.
//  Async reset mid-burst: return to IDLE, no pulses; memory side must be reset together.
// STRUCTURE
//  Shared defines: `DATA_WIDTH, `RAM_NUM, `CACHE_RAM_AW, `CACHE_BANK_NUM, plus new
//  `CACHE_INDEX_W(8), `CACHE_WOFS_W(2), FSM state encodings REFILL_IDLE/REQ/RECV/FIN.
//  Single module; no sub-module. Write outputs connect directly to data array wr_* ports.
// TESTING
//  1 miss_addr=0x0000_1238 (idx 0x23, word 2), beats A,B,C,D -> writes 0x08E/08F/08C/08D, crit=A, done@T+5.
//  2 word 0, rsp_valid toggling every other cycle -> 4 writes addr idx*4+0..3 in order, one done pulse.
//  3 beat 2 err=1 -> writes only beats 0,1; beats 2,3 no wr_en; refill_err_o=1, refill_done_o=0.
//  4 mem_req_ready_i held low 10 cycles -> req_valid/addr stable; req during busy ignored, single refill.
//  5 rst_n low mid-RECV after 2 beats -> next cycle all outputs 0, IDLE; new refill completes normally.
//  6 last asserted on beat 3 -> refill_err_o pulse, FSM back to IDLE, busy_o drops next cycle.

Source files
------------

// File: rtl/cache_refill_pkg.sv
// Shared constants, FSM encoding and address helper for the cache line-fill engine.
package cache_refill_pkg;

  localparam int CACHE_DATA_W   = 32;  // word / beat width
  localparam int CACHE_RAM_NUM  = 4;   // byte-wide RAMs per word
  localparam int CACHE_BANK_NUM = 4;   // beats per line
  localparam int CACHE_INDEX_W  = 8;   // line index width
  localparam int CACHE_WOFS_W   = 2;   // word-in-line offset width
  localparam int CACHE_RAM_AW   = CACHE_INDEX_W + CACHE_WOFS_W;

  typedef enum logic [1:0] {
    REFILL_IDLE = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_RECV = 2'd2,
    REFILL_FIN  = 2'd3
  } refill_state_e;

  // Data-array word address of a given word within a line.
  function automatic logic [CACHE_RAM_AW-1:0] line_word_addr(
    input logic [CACHE_INDEX_W-1:0] index,
    input logic [CACHE_WOFS_W-1:0]  wofs
  );
    return {index, wofs};
  endfunction

endpackage

// File: rtl/cache_refill.sv
// Line-fill engine: one wrapping 4-beat burst per miss, critical word first,
// each beat written to the data array one cycle after it is accepted.
module cache_refill
  import cache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = CACHE_DATA_W,
  parameter int BANK_NUM   = CACHE_RAM_NUM,
  parameter int RAM_AW     = CACHE_RAM_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  refill_req_i,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  output logic                  busy_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_err_i,
  input  logic                  mem_rsp_last_i,
  output logic [BANK_NUM-1:0]   wr_en_o,
  output logic [RAM_AW-1:0]     wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  crit_valid_o,
  output logic [DATA_WIDTH-1:0] crit_data_o,
  output logic                  refill_done_o,
  output logic                  refill_err_o
);

  // Bit position of the word offset inside the byte address.
  localparam int WOFS_LSB = 2;
  localparam int IDX_LSB  = WOFS_LSB + CACHE_WOFS_W;

  // Beat count of the final expected beat, and of an overrun beat.
  localparam logic [2:0] LAST_CNT = 3'(BANK_NUM - 1);
  localparam logic [2:0] OVER_CNT = 3'(BANK_NUM);

  refill_state_e               state;
  logic [CACHE_INDEX_W-1:0]    line_index;
  logic [CACHE_WOFS_W-1:0]     beat_ofs;
  logic [2:0]                  beat_cnt;
  logic                        err_flag;

  logic                        beat_err;
  logic                        beat_fin;
  logic                        line_bad;

  // Classify the beat currently offered: bus error, early last, or overrun all poison the line.
  always_comb begin
    beat_err = mem_rsp_err_i
             | (mem_rsp_last_i & (beat_cnt < LAST_CNT))
             | (beat_cnt == OVER_CNT);
    beat_fin = mem_rsp_last_i | (beat_cnt == OVER_CNT);
    line_bad = err_flag | beat_err;
  end

  // Refill FSM with registered handshake, array-write and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= REFILL_IDLE;
      line_index      <= '0;
      beat_ofs        <= '0;
      beat_cnt        <= '0;
      err_flag        <= 1'b0;
      busy_o          <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_rsp_ready_o <= 1'b0;
      wr_en_o         <= '0;
      wr_addr_o       <= '0;
      wr_data_o       <= '0;
      crit_valid_o    <= 1'b0;
      crit_data_o     <= '0;
      refill_done_o   <= 1'b0;
      refill_err_o    <= 1'b0;
    end else begin
      wr_en_o       <= '0;
      crit_valid_o  <= 1'b0;
      refill_done_o <= 1'b0;
      refill_err_o  <= 1'b0;
      case (state)
        REFILL_IDLE: begin
          if (refill_req_i) begin
            line_index      <= miss_addr_i[IDX_LSB +: CACHE_INDEX_W];
            beat_ofs        <= miss_addr_i[WOFS_LSB +: CACHE_WOFS_W];
            // Word-aligned burst start; the memory wraps within the line.
            mem_req_addr_o  <= miss_addr_i & ~ADDR_WIDTH'(3);
            mem_req_valid_o <= 1'b1;
            busy_o          <= 1'b1;
            err_flag        <= 1'b0;
            state           <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_rsp_ready_o <= 1'b1;
            beat_cnt        <= '0;
            state           <= REFILL_RECV;
          end
        end
        REFILL_RECV: begin
          if (mem_rsp_valid_i && mem_rsp_ready_o) begin
            if (!line_bad) begin
              wr_en_o   <= '1;
              wr_addr_o <= line_word_addr(line_index, beat_ofs);
              wr_data_o <= mem_rsp_data_i;
            end
            if ((beat_cnt == 3'd0) && !beat_err) begin
              crit_valid_o <= 1'b1;
              crit_data_o  <= mem_rsp_data_i;
            end
            beat_ofs <= beat_ofs + 2'd1;
            beat_cnt <= beat_cnt + 3'd1;
            err_flag <= line_bad;
            if (beat_fin) begin
              // Status pulses land in FIN, together with the last array write.
              mem_rsp_ready_o <= 1'b0;
              refill_done_o   <= ~line_bad;
              refill_err_o    <= line_bad;
              state           <= REFILL_FIN;
            end
          end
        end
        REFILL_FIN: begin
          busy_o   <= 1'b0;
          err_flag <= 1'b0;
          state    <= REFILL_IDLE;
        end
        default: state <= REFILL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for the cache line-fill engine.
module tb_cache_refill;
  import cache_refill_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        refill_req;
  logic [31:0] miss_addr;
  logic        busy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        mem_rsp_last;
  logic [3:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        refill_done;
  logic        refill_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  cache_refill dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .refill_req_i    (refill_req),
    .miss_addr_i     (miss_addr),
    .busy_o          (busy),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_ready_o (mem_rsp_ready),
    .mem_rsp_data_i  (mem_rsp_data),
    .mem_rsp_err_i   (mem_rsp_err),
    .mem_rsp_last_i  (mem_rsp_last),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data),
    .crit_valid_o    (crit_valid),
    .crit_data_o     (crit_data),
    .refill_done_o   (refill_done),
    .refill_err_o    (refill_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue a miss and complete the request handshake in the following cycle.
  task automatic start_refill(input string tag, input logic [31:0] addr);
    refill_req = 1'b1;
    miss_addr  = addr;
    tick();
    refill_req = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, mem_req_addr, addr & 32'hFFFF_FFFC);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk({tag, "_rsp_ready"}, 32'(mem_rsp_ready), 32'd1);
    chk({tag, "_req_dropped"}, 32'(mem_req_valid), 32'd0);
  endtask

  // Offer one beat for one cycle, then check the array write it produces.
  task automatic beat(input string tag, input logic [31:0] d, input logic e, input logic l,
                      input logic [3:0] exp_en, input logic [9:0] exp_addr);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    mem_rsp_err   = e;
    mem_rsp_last  = l;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_last  = 1'b0;
    chk({tag, "_wr_en"}, 32'(wr_en), 32'(exp_en));
    if (exp_en != 4'b0000) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_addr));
      chk({tag, "_wr_data"}, wr_data, d);
    end
  endtask

  // Status-pulse check in the cycle after the final beat, then the drop of busy.
  task automatic finish(input string tag, input logic exp_done, input logic exp_err);
    chk({tag, "_done"}, 32'(refill_done), 32'(exp_done));
    chk({tag, "_err"}, 32'(refill_err), 32'(exp_err));
    chk({tag, "_busy_fin"}, 32'(busy), 32'd1);
    chk({tag, "_rsp_ready_fin"}, 32'(mem_rsp_ready), 32'd0);
    tick();
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_done_clr"}, 32'(refill_done), 32'd0);
    chk({tag, "_err_clr"}, 32'(refill_err), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    refill_req    = 1'b0;
    miss_addr     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    mem_rsp_last  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_crit", 32'(crit_valid), 32'd0);
    chk("rst_done", 32'(refill_done), 32'd0);
    chk("rst_err", 32'(refill_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: index 0x23, word 2 -> wrap 2,3,0,1; critical word is A
    start_refill("t1", 32'h0000_1238);
    beat("t1_b0", 32'hAAAA_0001, 1'b0, 1'b0, 4'hF, 10'h08E);
    chk("t1_crit_valid", 32'(crit_valid), 32'd1);
    chk("t1_crit_data", crit_data, 32'hAAAA_0001);
    beat("t1_b1", 32'hBBBB_0002, 1'b0, 1'b0, 4'hF, 10'h08F);
    chk("t1_crit_once", 32'(crit_valid), 32'd0);
    beat("t1_b2", 32'hCCCC_0003, 1'b0, 1'b0, 4'hF, 10'h08C);
    chk("t1_no_early_done", 32'(refill_done), 32'd0);
    beat("t1_b3", 32'hDDDD_0004, 1'b0, 1'b1, 4'hF, 10'h08D);
    finish("t1", 1'b1, 1'b0);
    chk("t1_wr_idle", 32'(wr_en), 32'd0);

    // 2: word 0, beats separated by idle cycles
    start_refill("t2", 32'h0000_0A40);
    for (int i = 0; i < 4; i++) begin
      beat("t2_b", 32'h1000_0000 + 32'(i), 1'b0, (i == 3), 4'hF, 10'h290 + 10'(i));
      if (i < 3) begin
        tick();
        chk("t2_gap_wr", 32'(wr_en), 32'd0);
        chk("t2_gap_done", 32'(refill_done), 32'd0);
        chk("t2_gap_ready", 32'(mem_rsp_ready), 32'd1);
      end
    end
    finish("t2", 1'b1, 1'b0);

    // 3: error on the third beat poisons the rest of the line
    start_refill("t3", 32'h0000_0100);
    beat("t3_b0", 32'h3000_0000, 1'b0, 1'b0, 4'hF, 10'h040);
    beat("t3_b1", 32'h3000_0001, 1'b0, 1'b0, 4'hF, 10'h041);
    beat("t3_b2", 32'h3000_0002, 1'b1, 1'b0, 4'h0, 10'h000);
    chk("t3_ready_held", 32'(mem_rsp_ready), 32'd1);
    beat("t3_b3", 32'h3000_0003, 1'b0, 1'b1, 4'h0, 10'h000);
    finish("t3", 1'b0, 1'b1);

    // 4: request stalled by memory; a second miss during busy is ignored
    refill_req = 1'b1;
    miss_addr  = 32'h0000_5674;
    tick();
    miss_addr = 32'h0000_FFF0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_valid", 32'(mem_req_valid), 32'd1);
      chk("t4_stall_addr", mem_req_addr, 32'h0000_5674);
      tick();
    end
    refill_req    = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("t4_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    beat("t4_b0", 32'h4000_0000, 1'b0, 1'b0, 4'hF, 10'h19D);
    beat("t4_b1", 32'h4000_0001, 1'b0, 1'b0, 4'hF, 10'h19E);
    beat("t4_b2", 32'h4000_0002, 1'b0, 1'b0, 4'hF, 10'h19F);
    beat("t4_b3", 32'h4000_0003, 1'b0, 1'b1, 4'hF, 10'h19C);
    finish("t4", 1'b1, 1'b0);
    tick();
    chk("t4_no_second_req", 32'(mem_req_valid), 32'd0);
    chk("t4_still_idle", 32'(busy), 32'd0);

    // 5: asynchronous reset in the middle of the burst, then a clean refill
    start_refill("t5", 32'h0000_0200);
    beat("t5_b0", 32'h5000_0000, 1'b0, 1'b0, 4'hF, 10'h080);
    beat("t5_b1", 32'h5000_0001, 1'b0, 1'b0, 4'hF, 10'h081);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(mem_rsp_ready), 32'd0);
    chk("t5_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t5_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("t5_rst_req_addr", mem_req_addr, 32'd0);
    tick();
    chk("t5_rst_done", 32'(refill_done), 32'd0);
    chk("t5_rst_err", 32'(refill_err), 32'd0);
    rst_n = 1'b1;
    tick();
    start_refill("t5r", 32'h0000_0334);
    beat("t5r_b0", 32'h5100_0000, 1'b0, 1'b0, 4'hF, 10'h0CD);
    beat("t5r_b1", 32'h5100_0001, 1'b0, 1'b0, 4'hF, 10'h0CE);
    beat("t5r_b2", 32'h5100_0002, 1'b0, 1'b0, 4'hF, 10'h0CF);
    beat("t5r_b3", 32'h5100_0003, 1'b0, 1'b1, 4'hF, 10'h0CC);
    finish("t5r", 1'b1, 1'b0);

    // 6: last arrives on the third beat
    start_refill("t6", 32'h0000_0440);
    beat("t6_b0", 32'h6000_0000, 1'b0, 1'b0, 4'hF, 10'h110);
    beat("t6_b1", 32'h6000_0001, 1'b0, 1'b0, 4'hF, 10'h111);
    beat("t6_b2", 32'h6000_0002, 1'b0, 1'b1, 4'h0, 10'h000);
    finish("t6", 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
